// File: rtl/det_seq_ctrl_pkg.sv
// Shared types and constants for the determinant sequencer: FSM states,
// packed-word nibble layout and result widths.
package det_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL_AD,
    MUL_BC,
    OUT,
    DONE
  } state_t;

  localparam int WORD_W = 16;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 2 * NIB_W;
  localparam int DET_W  = 9;
  localparam int CNT_W  = 5;

  // Nibble positions inside a program word: {b, d, c, a}
  localparam int A_LSB = 0;
  localparam int C_LSB = 4;
  localparam int D_LSB = 8;
  localparam int B_LSB = 12;

  // ad - bc with both products zero-extended; the 9-bit difference is
  // already the two's-complement result because |ad - bc| <= 225.
  function automatic logic [DET_W-1:0] det_diff(input logic [PROD_W-1:0] prod_ad,
                                                input logic [PROD_W-1:0] prod_bc);
    return {1'b0, prod_ad} - {1'b0, prod_bc};
  endfunction

endpackage

// File: rtl/det_seq_ctrl_if.sv
// ROM fetch bus and valid/ready result port of the determinant sequencer.
interface det_seq_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  import det_seq_pkg::*;

  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DET_W-1:0] det_out;
  logic [ADDR_W-1:0]       det_addr;

  modport master (
    output rom_addr, out_valid, det_out, det_addr,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, det_out, det_addr,
    output rom_data, out_ready
  );

endinterface

// File: rtl/det_seq_ctrl_nibble_mul4.sv
// Combinational 4x4 -> 8-bit unsigned multiplier, time-shared by the
// sequencer for both partial products of the determinant.
module nibble_mul4
  import det_seq_pkg::*;
(
  input  logic [NIB_W-1:0]  x,
  input  logic [NIB_W-1:0]  y,
  output logic [PROD_W-1:0] p
);

  assign p = {{NIB_W{1'b0}}, x} * {{NIB_W{1'b0}}, y};

endmodule

// File: rtl/det_seq_ctrl.sv
// Walks the program ROM, computes ad-bc per word with one shared multiplier
// over two cycles and hands each signed result out over valid/ready.
module det_seq_ctrl
  import det_seq_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 16,
  parameter int LAST_ADDR    = 15,
  parameter int HALT_ON_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  det_seq_ctrl_if.master      bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    res_count
);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_W-1:0]       pc;
  logic [DATA_W-1:0]       instr;
  logic [PROD_W-1:0]       prod_ad;
  logic [DET_W-1:0]        det_q;
  logic [ADDR_W-1:0]       det_addr_q;
  logic                    out_valid_q;
  logic [NIB_W-1:0]        mul_x;
  logic [NIB_W-1:0]        mul_y;
  logic [PROD_W-1:0]       mul_p;
  logic                    handshake;
  logic                    at_last;
  logic                    zero_word;

  assign handshake = (state == OUT) && out_valid_q && bus.out_ready;
  assign at_last   = (pc == ADDR_W'(LAST_ADDR));
  assign zero_word = (HALT_ON_ZERO != 0) && (bus.rom_data == '0);

  nibble_mul4 u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (mul_p)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // abort has priority over start and the output handshake.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_next = FETCH;
        FETCH:      state_next = zero_word ? DONE : MUL_AD;
        MUL_AD:     state_next = MUL_BC;
        MUL_BC:     state_next = OUT;
        OUT:        if (handshake) state_next = at_last ? DONE : FETCH;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = state inside {FETCH, MUL_AD, MUL_BC, OUT};
    done  = (state == DONE);
    mul_x = instr[A_LSB +: NIB_W];
    mul_y = instr[D_LSB +: NIB_W];
    if (state == MUL_BC) begin
      mul_x = instr[B_LSB +: NIB_W];
      mul_y = instr[C_LSB +: NIB_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      instr       <= '0;
      prod_ad     <= '0;
      det_q       <= '0;
      det_addr_q  <= '0;
      out_valid_q <= 1'b0;
      res_count   <= '0;
    end else if (abort) begin
      pc          <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pc        <= '0;
            res_count <= '0;
          end
        end
        FETCH:  instr   <= bus.rom_data;
        MUL_AD: prod_ad <= mul_p;
        MUL_BC: begin
          det_q       <= det_diff(prod_ad, mul_p);
          det_addr_q  <= pc;
          out_valid_q <= 1'b1;
        end
        OUT: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            res_count   <= res_count + CNT_W'(1);
            // pc stays on LAST_ADDR so rom_addr holds through DONE
            if (!at_last) pc <= pc + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr  = pc;
  assign bus.out_valid = out_valid_q;
  assign bus.det_out   = det_q;
  assign bus.det_addr  = det_addr_q;

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Scoreboard bench for det_seq_ctrl: a word-level model queues expected
// results, an independent monitor checks every accepted output.
module tb_det_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic [4:0] res_count;

  logic [15:0] rom [16];
  logic [15:0] plan [9] = '{16'h1234, 16'h2138, 16'h1256, 16'h7757, 16'h7758,
                           16'h7758, 16'h7759, 16'h7758, 16'h7750};

  typedef struct {
    int det;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_n;
  int   end_addr;

  logic stalled = 1'b0;
  int   held_det;
  int   held_addr;

  always #5 clk = ~clk;

  det_seq_ctrl_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  det_seq_ctrl #(
    .ADDR_W       (4),
    .DATA_W       (16),
    .LAST_ADDR    (15),
    .HALT_ON_ZERO (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .res_count (res_count)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Expected results straight from the word semantics: walk addresses,
  // stop on a zero word, otherwise emit a*d - b*c.
  task automatic build_model();
    exp_n    = 0;
    end_addr = 15;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      int a, b, c, d;
      w = rom[i];
      if (w == 16'h0000) begin
        end_addr = i;
        break;
      end
      a = int'(w[3:0]);
      c = int'(w[7:4]);
      d = int'(w[11:8]);
      b = int'(w[15:12]);
      exp_q.push_back('{det: a * d - b * c, addr: i});
      exp_n++;
    end
  endtask

  task automatic load_plan();
    for (int i = 0; i < 16; i++) rom[i] = (i < 9) ? plan[i] : 16'h0000;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic wait_addr(input int addr, input int budget);
    int n = 0;
    while (bus.rom_addr !== 4'(addr) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_addr", bus.rom_addr, addr);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("valid_reached", bus.out_valid, 1);
  endtask

  task automatic end_run(input int cnt, input int addr);
    check("res_count", res_count, cnt);
    check("rom_addr_end", bus.rom_addr, addr);
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, bus.rom_addr, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_det_out"}, bus.det_out, 0);
    check({tag, "_det_addr"}, bus.det_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_res_count"}, res_count, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (stalled) begin
          check("hold_det", $signed(bus.det_out), held_det);
          check("hold_addr", bus.det_addr, held_addr);
        end
        if (bus.out_ready === 1'b1) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got det=%0d addr=%0d, required no result",
                     $signed(bus.det_out), bus.det_addr);
          end else begin
            e = exp_q.pop_front();
            check("det_out", $signed(bus.det_out), e.det);
            check("det_addr", bus.det_addr, e.addr);
          end
        end else begin
          stalled   = 1'b1;
          held_det  = int'($signed(bus.det_out));
          held_addr = int'(bus.det_addr);
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : stimulus
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;

    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reference program, no backpressure, halts on the zero word at addr 9
    load_plan();
    build_model();
    pulse_start();
    wait_done(1'b0, 200);
    end_run(9, 9);

    // Start from DONE with the first result stalled for five cycles
    bus.out_ready = 1'b0;
    build_model();
    pulse_start();
    check("restart_done_low", done, 0);
    check("restart_count_clr", res_count, 0);
    wait_valid(20);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_pc", bus.rom_addr, 0);
      check("stall_count", res_count, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("after_hs_count", res_count, 1);
    wait_done(1'b0, 200);
    end_run(9, 9);

    // All-ones program runs to LAST_ADDR
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    build_model();
    pulse_start();
    wait_done(1'b0, 200);
    end_run(16, 15);

    // Abort while addr 2 is in MUL_BC
    load_plan();
    build_model();
    pulse_start();
    wait_addr(2, 40);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_pc", bus.rom_addr, 0);
    check("abort_count_kept", res_count, 2);
    check("abort_done", done, 0);
    repeat (4) @(posedge clk);
    #1 check("abort_no_result", exp_q.size(), 7);
    exp_q.delete();
    build_model();
    pulse_start();
    wait_done(1'b0, 200);
    end_run(9, 9);

    // Asynchronous reset while a result waits in OUT
    build_model();
    pulse_start();
    wait_addr(2, 40);
    bus.out_ready = 1'b0;
    wait_valid(20);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_done", done, 0);

    // start while busy must not restart the run
    build_model();
    pulse_start();
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1'b0, 200);
    end_run(9, 9);

    // Random programs with random backpressure
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++)
        rom[i] = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      build_model();
      pulse_start();
      wait_done(1'b1, 3000);
      bus.out_ready = 1'b1;
      end_run(exp_n, end_addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
